// File: rtl/bit_sayar_birimi_if.sv
// Request/result handshake bundle for the bit counting unit.
// The master side issues operands and accepts results; the slave side is the counter.
interface bit_sayar_birimi_if #(
  parameter int VERI_BIT  = 32,
  parameter int PARCA_BIT = 8
);
  localparam int SAYI_BIT = $clog2(VERI_BIT) + 1;

  logic                istek_gecerli_i;
  logic                istek_hazir_o;
  logic [1:0]          islem_i;
  logic [VERI_BIT-1:0] deger_i;
  logic                sonuc_gecerli_o;
  logic                sonuc_hazir_i;
  logic [SAYI_BIT-1:0] sonuc_o;
  logic                hepsi_sifir_o;
  logic                iptal_i;

  modport master (
    output istek_gecerli_i, islem_i, deger_i, sonuc_hazir_i, iptal_i,
    input  istek_hazir_o, sonuc_gecerli_o, sonuc_o, hepsi_sifir_o
  );

  modport slave (
    input  istek_gecerli_i, islem_i, deger_i, sonuc_hazir_i, iptal_i,
    output istek_hazir_o, sonuc_gecerli_o, sonuc_o, hepsi_sifir_o
  );
endinterface

// File: rtl/bit_sayar_birimi.sv
// Multi-cycle CTZ / CLZ / CPOP unit examining PARCA_BIT operand bits per cycle.
// CLZ is computed as CTZ of the bit-reversed operand; CTZ/CLZ stop at the first set bit.
module bit_sayar_birimi #(
  parameter int VERI_BIT  = 32,
  parameter int PARCA_BIT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bit_sayar_birimi_if.slave  bus
);
  localparam int SAYI_BIT     = $clog2(VERI_BIT) + 1;
  localparam int PARCA_SAYISI = VERI_BIT / PARCA_BIT;
  localparam int IDX_W        = (PARCA_SAYISI > 1) ? $clog2(PARCA_SAYISI) : 1;
  localparam logic [IDX_W-1:0] SON_IDX = IDX_W'(PARCA_SAYISI - 1);

  typedef enum logic [1:0] {BOSTA, SAYIM, SONUC} durum_t;

  function automatic logic [SAYI_BIT-1:0] bir_say(input logic [PARCA_BIT-1:0] p);
    logic [SAYI_BIT-1:0] n;
    n = '0;
    for (int i = 0; i < PARCA_BIT; i++) n = n + SAYI_BIT'(p[i]);
    return n;
  endfunction

  // A zero chunk yields PARCA_BIT so the running count carries on to the next chunk.
  function automatic logic [SAYI_BIT-1:0] sondaki_sifir(input logic [PARCA_BIT-1:0] p);
    logic [SAYI_BIT-1:0] n;
    n = SAYI_BIT'(PARCA_BIT);
    for (int i = PARCA_BIT - 1; i >= 0; i--) if (p[i]) n = SAYI_BIT'(i);
    return n;
  endfunction

  function automatic logic [VERI_BIT-1:0] ters(input logic [VERI_BIT-1:0] v);
    logic [VERI_BIT-1:0] r;
    for (int i = 0; i < VERI_BIT; i++) r[i] = v[VERI_BIT-1-i];
    return r;
  endfunction

  durum_t              durum;
  logic                mod_cpop;
  logic [VERI_BIT-1:0] calisma;
  logic [SAYI_BIT-1:0] sayac;
  logic [IDX_W-1:0]    parca_idx;
  logic                sifir_r;
  logic                istek_hazir_r;
  logic                sonuc_gecerli_r;
  logic [SAYI_BIT-1:0] sonuc_r;
  logic                hepsi_sifir_r;

  logic [PARCA_BIT-1:0] parca;
  logic [SAYI_BIT-1:0]  yeni_sayac;
  logic                 bitti;

  always_comb begin
    parca      = calisma[PARCA_BIT-1:0];
    yeni_sayac = sayac;
    bitti      = (parca_idx == SON_IDX);
    if (mod_cpop) begin
      yeni_sayac = sayac + bir_say(parca);
    end else begin
      yeni_sayac = sayac + sondaki_sifir(parca);
      if (parca != '0) bitti = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.iptal_i) begin
      durum           <= BOSTA;
      mod_cpop        <= 1'b0;
      calisma         <= '0;
      sayac           <= '0;
      parca_idx       <= '0;
      sifir_r         <= 1'b0;
      istek_hazir_r   <= 1'b1;
      sonuc_gecerli_r <= 1'b0;
      sonuc_r         <= '0;
      hepsi_sifir_r   <= 1'b0;
    end else begin
      case (durum)
        BOSTA: begin
          if (bus.istek_gecerli_i) begin
            mod_cpop      <= (bus.islem_i == 2'b10);
            calisma       <= (bus.islem_i == 2'b01) ? ters(bus.deger_i) : bus.deger_i;
            sifir_r       <= (bus.deger_i == '0);
            sayac         <= '0;
            parca_idx     <= '0;
            istek_hazir_r <= 1'b0;
            durum         <= SAYIM;
          end
        end
        SAYIM: begin
          sayac     <= yeni_sayac;
          calisma   <= calisma >> PARCA_BIT;
          parca_idx <= parca_idx + 1'b1;
          if (bitti) begin
            sonuc_r         <= yeni_sayac;
            hepsi_sifir_r   <= sifir_r;
            sonuc_gecerli_r <= 1'b1;
            durum           <= SONUC;
          end
        end
        SONUC: begin
          if (bus.sonuc_hazir_i) begin
            sonuc_gecerli_r <= 1'b0;
            sonuc_r         <= '0;
            hepsi_sifir_r   <= 1'b0;
            istek_hazir_r   <= 1'b1;
            durum           <= BOSTA;
          end
        end
        default: begin
          istek_hazir_r   <= 1'b1;
          sonuc_gecerli_r <= 1'b0;
          sonuc_r         <= '0;
          hepsi_sifir_r   <= 1'b0;
          durum           <= BOSTA;
        end
      endcase
    end
  end

  assign bus.istek_hazir_o   = istek_hazir_r;
  assign bus.sonuc_gecerli_o = sonuc_gecerli_r;
  assign bus.sonuc_o         = sonuc_r;
  assign bus.hepsi_sifir_o   = hepsi_sifir_r;
endmodule
